// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and the gate under test / consumer.
// Optional compare signals exist only with TRUTH_TABLE_SEQUENCER_CHECK_EN.
interface truth_table_sequencer_if #(
    parameter int N_IN = 2
) ();
    localparam int NV = 1 << N_IN;

    // start is a level request with no ready: it is accepted only at an edge
    // where the sequencer is idle (busy=0, done=0); at any other time it is dropped.
    logic            start;
    logic [N_IN-1:0] stim;
    logic            dut_o;
    logic            busy;
    logic            done;
    logic [NV-1:0]   truth;
`ifdef TRUTH_TABLE_SEQUENCER_CHECK_EN
    logic [NV-1:0]   expected;
    logic            mismatch;
    logic [N_IN:0]   err_cnt;

    modport master (input start, dut_o, expected,
                    output stim, busy, done, truth, mismatch, err_cnt);
    modport slave  (output start, dut_o, expected,
                    input stim, busy, done, truth, mismatch, err_cnt);
`else
    modport master (input start, dut_o, output stim, busy, done, truth);
    modport slave  (output start, dut_o, input stim, busy, done, truth);
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all input vectors onto a small gate and captures its truth table.
// Optional compare against a reference table: define TRUTH_TABLE_SEQUENCER_CHECK_EN.
module truth_table_sequencer #(
    parameter int N_IN      = 2,
    parameter int DWELL     = 50,
    parameter int START_VEC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_sequencer_if.master bus,
    output logic [1:0]              dbg_state_o
);
    localparam int NV = 1 << N_IN;
    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [N_IN:0]   vec_q, vec_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [NV-1:0]   truth_q, truth_d, truth_cap;
    logic            dwell_end, last_cap;

    assign dwell_end = (state_q == S_DRIVE) && (dwell_q == DW'(DWELL - 1));
    assign last_cap  = dwell_end && (vec_q == (N_IN + 1)'(NV - 1));

    // Table as it will look once the current dwell's sample is written.
    always_comb begin
        truth_cap         = truth_q;
        truth_cap[stim_q] = bus.dut_o;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_DRIVE;
            S_DRIVE: if (last_cap)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q == S_DRIVE);
        bus.done    = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

    assign bus.stim  = stim_q;
    assign bus.truth = truth_q;

    always_comb begin
        stim_d  = stim_q;
        truth_d = truth_q;
        dwell_d = dwell_q;
        vec_d   = vec_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                stim_d  = N_IN'(START_VEC);
                truth_d = '0;
                dwell_d = '0;
                vec_d   = '0;
            end
            S_DRIVE: if (dwell_end) begin
                truth_d = truth_cap;
                dwell_d = '0;
                vec_d   = vec_q + (N_IN + 1)'(1);
                stim_d  = last_cap ? '0 : stim_q + N_IN'(1);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim_q  <= '0;
            truth_q <= '0;
            dwell_q <= '0;
            vec_q   <= '0;
        end else begin
            stim_q  <= stim_d;
            truth_q <= truth_d;
            dwell_q <= dwell_d;
            vec_q   <= vec_d;
        end
    end

`ifdef TRUTH_TABLE_SEQUENCER_CHECK_EN
    logic [NV-1:0] exp_q, exp_d;
    logic          mis_q, mis_d;
    logic [N_IN:0] err_q, err_d;

    function automatic logic [N_IN:0] popcount(input logic [NV-1:0] x);
        logic [N_IN:0] cnt;
        cnt = '0;
        for (int i = 0; i < NV; i++) cnt = cnt + (N_IN + 1)'(x[i]);
        return cnt;
    endfunction

    // The final sample is folded in combinationally so the verdict lands with done.
    always_comb begin
        exp_d = exp_q;
        mis_d = mis_q;
        err_d = err_q;
        if (state_q == S_IDLE && bus.start) begin
            exp_d = bus.expected;
            mis_d = 1'b0;
            err_d = '0;
        end else if (last_cap) begin
            mis_d = (truth_cap != exp_q);
            err_d = popcount(truth_cap ^ exp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q <= '0;
            mis_q <= 1'b0;
            err_q <= '0;
        end else begin
            exp_q <= exp_d;
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end

    assign bus.mismatch = mis_q;
    assign bus.err_cnt  = err_q;
`endif
endmodule
